// File: rtl/grad_xy_if.sv
// grad_xy_if: stream bundle for the grey-gradient stage.
//   Input side : pixel_in (24b RGB, R in [7:0]), de_in, vsync_in
//   Output side: gx_out/gy_out (signed 9b), x_out/y_out (centre coords),
//                de_out, vsync_out
// master = pixel source / result consumer, slave = grad_xy.
interface grad_xy_if #(
  parameter int LEN_X = 6,
  parameter int LEN_Y = 7
);
  logic [23:0]       pixel_in;
  logic              de_in;
  logic              vsync_in;
  logic signed [8:0] gx_out;
  logic signed [8:0] gy_out;
  logic [LEN_X-1:0]  x_out;
  logic [LEN_Y-1:0]  y_out;
  logic              de_out;
  logic              vsync_out;

  modport master (
    output pixel_in, de_in, vsync_in,
    input  gx_out, gy_out, x_out, y_out, de_out, vsync_out
  );

  modport slave (
    input  pixel_in, de_in, vsync_in,
    output gx_out, gy_out, x_out, y_out, de_out, vsync_out
  );
endinterface

// File: rtl/grad_xy.sv
// grad_xy: streaming centred-difference gradient stage.
//   Converts each RGB beat to 8-bit grey, keeps the two previous lines in
//   block-RAM line buffers and emits gx = P(x+1,y)-P(x-1,y) and
//   gy = P(x,y+1)-P(x,y-1) for every interior pixel of the frame.
// Ports:
//   clk    : pixel clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : grad_xy_if.slave (pixel_in/de_in/vsync_in in,
//            gx_out/gy_out/x_out/y_out/de_out/vsync_out out)
// Timing: results for input beat (x,y) appear 2 clk later with centre
// (x-1,y-1); vsync_out is vsync_in delayed 2 clk.
module grad_xy #(
  parameter int SIZE_X = 64,
  parameter int SIZE_Y = 128,
  parameter int LEN_X  = $clog2(SIZE_X),
  parameter int LEN_Y  = $clog2(SIZE_Y)
) (
  input  logic    clk,
  input  logic    rst_n,
  grad_xy_if.slave bus
);

  localparam logic [LEN_X-1:0] X_LAST = LEN_X'(SIZE_X - 1);
  localparam logic [LEN_Y-1:0] Y_LAST = LEN_Y'(SIZE_Y - 1);
  // Grey weights for R, G, B packed as bytes [7:0], [15:8], [23:16].
  localparam logic [23:0] WEIGHTS = {8'd29, 8'd150, 8'd77};

  // ---------------------------------------------------------------
  // Input coordinate counters
  // ---------------------------------------------------------------
  logic [LEN_X-1:0] x_cnt_reg;
  logic [LEN_Y-1:0] y_cnt_reg;
  logic [LEN_X-1:0] pix_x;
  logic [LEN_Y-1:0] pix_y;

  // A beat arriving together with vsync is pixel (0,0) of the new frame.
  assign pix_x = bus.vsync_in ? '0 : x_cnt_reg;
  assign pix_y = bus.vsync_in ? '0 : y_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_reg <= '0;
      y_cnt_reg <= '0;
    end else if (bus.vsync_in) begin
      x_cnt_reg <= bus.de_in ? LEN_X'(1) : '0;
      y_cnt_reg <= '0;
    end else if (bus.de_in) begin
      if (x_cnt_reg == X_LAST) begin
        x_cnt_reg <= '0;
        y_cnt_reg <= (y_cnt_reg == Y_LAST) ? '0 : y_cnt_reg + LEN_Y'(1);
      end else begin
        x_cnt_reg <= x_cnt_reg + LEN_X'(1);
      end
    end
  end

  // ---------------------------------------------------------------
  // Grey conversion: (77R + 150G + 29B + 128) >> 8, fits 16 bits.
  // ---------------------------------------------------------------
  logic [15:0] prod [3];
  logic [15:0] grey_sum;
  logic [7:0]  grey_next;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_weight
      assign prod[gi] = 16'(bus.pixel_in[gi*8 +: 8]) * 16'(WEIGHTS[gi*8 +: 8]);
    end
  endgenerate

  assign grey_sum  = prod[0] + prod[1] + prod[2] + 16'd128;
  assign grey_next = grey_sum[15:8];

  // ---------------------------------------------------------------
  // Stage 1: registered grey and coordinates of the beat
  // ---------------------------------------------------------------
  logic             s1_valid_reg;
  logic [7:0]       grey_reg;
  logic [LEN_X-1:0] s1_x_reg;
  logic [LEN_Y-1:0] s1_y_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      grey_reg     <= '0;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
    end else begin
      s1_valid_reg <= bus.de_in;
      if (bus.de_in) begin
        grey_reg <= grey_next;
        s1_x_reg <= pix_x;
        s1_y_reg <= pix_y;
      end
    end
  end

  // ---------------------------------------------------------------
  // Line buffers (LB0 = row y-1, LB1 = row y-2), not reset.
  // Read is issued with the input beat so the data lines up with the
  // registered grey; the write for that beat happens one clock later at
  // the same address, so each location is read before it is rewritten.
  // ---------------------------------------------------------------
  logic [7:0] lb0_mem [SIZE_X];
  logic [7:0] lb1_mem [SIZE_X];
  logic [7:0] lb0_rd_reg;
  logic [7:0] lb1_rd_reg;

  always_ff @(posedge clk) begin
    if (bus.de_in) begin
      lb0_rd_reg <= lb0_mem[pix_x];
      lb1_rd_reg <= lb1_mem[pix_x];
    end
    if (s1_valid_reg) begin
      lb0_mem[s1_x_reg] <= grey_reg;
      lb1_mem[s1_x_reg] <= lb0_rd_reg;
    end
  end

  // ---------------------------------------------------------------
  // Window taps. The current column comes straight from stage 1; the
  // delayed taps below hold the older columns that the differences need.
  // ---------------------------------------------------------------
  logic [7:0] r0_d1_reg;   // row y,   column x-1
  logic [7:0] r1_d1_reg;   // row y-1, column x-1
  logic [7:0] r1_d2_reg;   // row y-1, column x-2
  logic [7:0] r2_d1_reg;   // row y-2, column x-1

  logic signed [8:0] gx_next;
  logic signed [8:0] gy_next;
  logic              out_valid_next;

  assign gx_next = {1'b0, lb0_rd_reg} - {1'b0, r1_d2_reg};
  assign gy_next = {1'b0, r0_d1_reg}  - {1'b0, r2_d1_reg};
  // Beats with x<2 or y<2 still shift the window but never emit, which keeps
  // line-wrap and new-frame garbage out of the results.
  assign out_valid_next = s1_valid_reg && (s1_x_reg >= LEN_X'(2)) &&
                          (s1_y_reg >= LEN_Y'(2));

  // ---------------------------------------------------------------
  // Stage 2: shift window, register results
  // ---------------------------------------------------------------
  logic              de_reg;
  logic signed [8:0] gx_reg;
  logic signed [8:0] gy_reg;
  logic [LEN_X-1:0]  x_reg;
  logic [LEN_Y-1:0]  y_reg;
  logic              vs_d1_reg;
  logic              vs_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_d1_reg  <= '0;
      r1_d1_reg  <= '0;
      r1_d2_reg  <= '0;
      r2_d1_reg  <= '0;
      de_reg     <= 1'b0;
      gx_reg     <= '0;
      gy_reg     <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      vs_d1_reg  <= 1'b0;
      vs_out_reg <= 1'b0;
    end else begin
      vs_d1_reg  <= bus.vsync_in;
      vs_out_reg <= vs_d1_reg;
      de_reg     <= out_valid_next;
      if (s1_valid_reg) begin
        r0_d1_reg <= grey_reg;
        r1_d1_reg <= lb0_rd_reg;
        r1_d2_reg <= r1_d1_reg;
        r2_d1_reg <= lb1_rd_reg;
      end
      if (out_valid_next) begin
        gx_reg <= gx_next;
        gy_reg <= gy_next;
        x_reg  <= s1_x_reg - LEN_X'(1);
        y_reg  <= s1_y_reg - LEN_Y'(1);
      end
    end
  end

  assign bus.de_out    = de_reg;
  assign bus.gx_out    = gx_reg;
  assign bus.gy_out    = gy_reg;
  assign bus.x_out     = x_reg;
  assign bus.y_out     = y_reg;
  assign bus.vsync_out = vs_out_reg;

endmodule

// File: tb/tb_grad_xy.sv
// tb_grad_xy: scoreboard bench for grad_xy on an 8x8 frame.
// Stimulus pushes hand-derived expected gradients (with their due cycle)
// into a queue; a negedge monitor pops and compares each de_out beat.
module tb_grad_xy;
  localparam int SX = 8;
  localparam int SY = 8;
  localparam int LX = 3;
  localparam int LY = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grad_xy_if #(.LEN_X(LX), .LEN_Y(LY)) bus ();

  grad_xy #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int gx;
    int gy;
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   vq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;
  int   bx = 0;
  int   by = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-derived expectations per test pattern (centre cx, cy).
  function automatic void expected(input int mode, input int cx, input int cy,
                                   output int gx, output int gy);
    gx = 0;
    gy = 0;
    case (mode)
      1: gx = 20;                                  // grey = 10*x
      2: gx = -20;                                 // grey = 70-10*x
      3: gy = 10;                                  // grey = 5*y
      4: gx = (cx == 3 || cx == 4) ? 77 : 0;       // black | red edge
      6: gy = 40;                                  // grey = 20*y
      default: ;                                   // flat fields
    endcase
  endfunction

  function automatic logic [23:0] pix(input int mode, input int x, input int y);
    logic [7:0] g;
    g = 8'd0;
    case (mode)
      0: g = 8'd100;
      1: g = 8'(10 * x);
      2: g = 8'(70 - 10 * x);
      3: g = 8'(5 * y);
      4: return (x < 4) ? 24'h000000 : 24'h0000FF;
      5: g = 8'd250;
      6: g = 8'(20 * y);
      default: g = 8'd0;
    endcase
    return {g, g, g};
  endfunction

  task automatic send(input bit de, input bit vs, input int mode);
    exp_t e;
    int gx, gy;
    @(posedge clk);
    #1;
    if (vs) begin
      bx = 0;
      by = 0;
      vq.push_back(cyc + 2);
    end
    bus.de_in    = de;
    bus.vsync_in = vs;
    bus.pixel_in = de ? pix(mode, bx, by) : 24'($urandom);
    if (de) begin
      if (bx >= 2 && by >= 2) begin
        expected(mode, bx - 1, by - 1, gx, gy);
        e.gx = gx; e.gy = gy; e.x = bx - 1; e.y = by - 1; e.cyc = cyc + 2;
        q.push_back(e);
      end
      if (bx == SX - 1) begin
        bx = 0;
        by = (by == SY - 1) ? 0 : by + 1;
      end else begin
        bx = bx + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 0);
  endtask

  task automatic frame(input int mode, input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      send(1'b1, 1'b0, mode);
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  task automatic check_end(input string name, input int exp_cnt);
    idle(5);
    checks++;
    if (out_cnt != exp_cnt || q.size() != 0 || vq.size() != 0) begin
      errors++;
      $display("FAIL %s: beats=%0d pending=%0d vs_pending=%0d, required beats=%0d pending=0",
               name, out_cnt, q.size(), vq.size(), exp_cnt);
    end
    $display("frame %s: %0d gradient beats", name, out_cnt);
    out_cnt = 0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.de_out) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_de: cyc=%0d x=%0d y=%0d gx=%0d gy=%0d",
                   cyc, bus.x_out, bus.y_out, bus.gx_out, bus.gy_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          out_cnt++;
          if (int'(bus.gx_out) != e.gx || int'(bus.gy_out) != e.gy ||
              int'(bus.x_out) != e.x || int'(bus.y_out) != e.y || cyc != e.cyc) begin
            errors++;
            $display("FAIL grad: got (%0d,%0d) gx=%0d gy=%0d cyc=%0d, required (%0d,%0d) gx=%0d gy=%0d cyc=%0d",
                     bus.x_out, bus.y_out, bus.gx_out, bus.gy_out, cyc,
                     e.x, e.y, e.gx, e.gy, e.cyc);
          end else begin
            $display("beat (%0d,%0d) gx=%0d gy=%0d cyc=%0d",
                     bus.x_out, bus.y_out, bus.gx_out, bus.gy_out, cyc);
          end
        end
      end
      if (bus.vsync_out) begin
        checks++;
        if (vq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vsync: cyc=%0d, required none", cyc);
        end else begin
          int ev;
          ev = vq.pop_front();
          if (cyc != ev) begin
            errors++;
            $display("FAIL vsync_delay: cyc=%0d, required %0d", cyc, ev);
          end else begin
            $display("vsync_out cyc=%0d", cyc);
          end
        end
      end
    end
  end

  initial begin
    bus.de_in    = 1'b0;
    bus.vsync_in = 1'b0;
    bus.pixel_in = '0;

    // Reset held with de_in toggling: outputs stay cleared.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      bus.de_in    = ~bus.de_in;
      bus.pixel_in = 24'($urandom);
      bus.vsync_in = (i == 3);
      @(negedge clk);
      checks++;
      if (bus.de_out !== 1'b0 || bus.vsync_out !== 1'b0 || bus.gx_out !== 9'sd0 ||
          bus.gy_out !== 9'sd0 || bus.x_out !== '0 || bus.y_out !== '0) begin
        errors++;
        $display("FAIL reset_state: de=%b vs=%b gx=%0d gy=%0d x=%0d y=%0d, required all 0",
                 bus.de_out, bus.vsync_out, bus.gx_out, bus.gy_out, bus.x_out, bus.y_out);
      end else begin
        $display("reset cycle %0d: outputs cleared", i);
      end
    end
    @(posedge clk);
    #1;
    bus.de_in    = 1'b0;
    bus.vsync_in = 1'b0;
    rst_n        = 1'b1;
    bx = 0;
    by = 0;

    frame(0, SX * SY, 1'b0); send(1'b0, 1'b1, 0); check_end("flat", 36);
    frame(1, SX * SY, 1'b1); send(1'b0, 1'b1, 0); check_end("hramp_gaps", 36);
    frame(2, SX * SY, 1'b0); send(1'b0, 1'b1, 0); check_end("hramp_mirror", 36);
    frame(3, SX * SY, 1'b0); send(1'b0, 1'b1, 0); check_end("vramp", 36);
    frame(4, SX * SY, 1'b0); send(1'b0, 1'b1, 0); check_end("colour", 36);

    // Abort after 3 lines, then a full frame: no stale rows in results.
    frame(5, 3 * SX, 1'b0);  send(1'b0, 1'b1, 0);
    frame(6, SX * SY, 1'b0); send(1'b0, 1'b1, 0); check_end("abort_restart", 42);

    // vsync coincident with de: that beat is pixel (0,0).
    frame(1, 10, 1'b0);
    send(1'b1, 1'b1, 1);
    frame(1, SX * SY - 1, 1'b0); send(1'b0, 1'b1, 0); check_end("vsync_de", 36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grad_xy.md
Name: grad_xy

Overview:
- Streaming gradient stage fed by the RGB pixel source (pixel/de/vsync stream, one pixel per de beat, raster order).
- Converts each pixel to 8-bit grey, buffers two lines, and emits centred-difference gradients gx, gy with centre coordinates for every interior pixel.
- Output feeds the HOG magnitude/orientation stage of the car-detection pipeline.

Parameters:
SIZE_X, 64, active pixels per line
SIZE_Y, 128, lines per frame
LEN_X, $clog2(SIZE_X), x coordinate width
LEN_Y, $clog2(SIZE_Y), y coordinate width

Ports:
clk  in  1  pixel clock, rising edge
rst_n  in  1  asynchronous active-low reset
pixel_in  in  24  [7:0]=R, [15:8]=G, [23:16]=B
de_in  in  1  pixel_in valid this cycle
vsync_in  in  1  one-cycle end-of-frame pulse
gx_out  out  9  signed P(x+1,y)-P(x-1,y)
gy_out  out  9  signed P(x,y+1)-P(x,y-1)
x_out  out  LEN_X  centre column of current gradient
y_out  out  LEN_Y  centre row of current gradient
de_out  out  1  gx/gy/x/y valid
vsync_out  in→out  1  vsync_in delayed 2 cycles

Behaviour:
- Reset (rst_n low, async): de_out=0, vsync_out=0, gx_out=gy_out=0, x_out=y_out=0; x/y counters=0; pipeline valids cleared. Line-buffer RAM is not reset.
- Grey, stage 1 (registered): Y=(77*R+150*G+29*B+128)>>8, 16-bit intermediate; max result is 255.
- Input counters advance on de_in only:
  - x increments per beat; at SIZE_X-1 it wraps to 0 and y increments.
  - y wraps from SIZE_Y-1 to 0.
  - Gaps in de_in stall everything: no bubble is inserted into window state.
- Two line buffers of SIZE_X x 8 bits (LB0 = row y-1, LB1 = row y-2), addressed by x:
  - Per grey beat: read LB0[x] and LB1[x], write LB1[x]<=LB0[x], write LB0[x]<=grey.
  - Read-before-write at the same address.
- Three 3-tap shift registers (rows y-2, y-1, y) shift on each grey beat.
- Gradient for centre (x-1,y-1) is computed when grey(x,y) arrives:
  - gx = row_{y-1}[x] - row_{y-1}[x-2]
  - gy = row_y[x-1] - row_{y-2}[x-1]
  - 9-bit two's complement; range -255..255, no saturation needed.
- Output valid only when incoming x>=2 and y>=2. Yields (SIZE_X-2)*(SIZE_Y-2) de_out beats per frame; border pixels produce no output.
- Latency: de_out/gx/gy/x_out/y_out update exactly 2 clk after the de_in beat carrying pixel (x,y), with x_out=x-1, y_out=y-1. Outputs hold their last value while de_out=0.
- Across a line wrap, x<2 beats shift the window but emit nothing, so no cross-line mixing appears at the output.
- vsync_in:
  - Clears the x/y counters at the next edge.
  - Propagates to vsync_out 2 clk later, behind the last gradient of the frame.
  - If vsync_in and de_in coincide, vsync wins: counters clear and that beat becomes pixel (0,0) of the new frame (next beat is (1,0)).
- vsync mid-frame aborts the frame: counters restart and stale line-buffer data is never emitted, because output requires y>=2 of the new frame.
- Reset mid-frame: identical restart; any in-flight de_out is dropped.

Test Plan:
1. rst_n=0 with de_in toggling -> de_out=0, vsync_out=0, gx_out=gy_out=0 throughout. Release -> first valid output only after two full lines.
2. SIZE_X=8, SIZE_Y=8, all pixels R=G=B=100 -> exactly 36 de_out beats, all gx=gy=0. First beat has x_out=1, y_out=1 and appears 2 clk after the (2,2) input beat. Last beat is (6,6). vsync_out arrives 2 clk after vsync_in.
3. Horizontal ramp R=G=B=10*x -> every output gx=+20, gy=0. Mirrored ramp 70-10*x -> gx=-20.
4. Vertical ramp R=G=B=5*y -> gy=+10, gx=0 on all 36 beats.
5. Colour check, grey 0 for x<4 and pure red (255,0,0) for x>=4 -> grey=77. gx=77 at x_out=3 and 4, 0 elsewhere; gy=0.
6. Two cases on an 8x8 frame:
   - vsync_in after 3 lines, then a full frame of gray=y*20 -> no output before the new frame's (1,1) centre; all gy=40, 36 beats.
   - vsync_in coincident with de_in -> that beat is counted as (0,0).
